instr_fetch: RTL and testbench

- Sequential instruction-fetch/issue front end for the Beta core.
- Generates word addresses into a synchronous instruction memory and buffers returned words in a 2-entry queue.
- Presents one instruction per cycle as `opCode`/`funct` plus the full word to the `ctl` decoder and datapath.
- Absorbs downstream stalls without losing in-flight reads, and handles branch/jump redirects by flushing.

---
 rtl/instr_fetch_if.sv | 48 ++++
 rtl/instr_fetch.sv | 153 +++++++++++++++
 tb/tb_instr_fetch.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_if
// Description : Bundle of instruction-memory, pipeline-control and
//               instruction-issue signals between the fetch unit and its
//               surroundings. The master modport is the fetch unit.
//               Optional perf ports exist only when FETCH_PERF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_if;
  logic        imemRd;
  logic [31:0] imemAddr;
  logic [31:0] imemData;
  logic        stall;
  logic        redirect;
  logic [31:0] redirectPC;
  logic        instValid;
  logic [31:0] instr;
  logic [5:0]  opCode;
  logic [5:0]  funct;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
`ifdef FETCH_PERF_EN
  logic [31:0] fetchCount;
  logic [31:0] stallCount;

  modport master (
    input  imemData, stall, redirect, redirectPC,
    output imemRd, imemAddr, instValid, instr, opCode, funct, pc, pcPlus4,
    output fetchCount, stallCount
  );
  modport slave (
    output imemData, stall, redirect, redirectPC,
    input  imemRd, imemAddr, instValid, instr, opCode, funct, pc, pcPlus4,
    input  fetchCount, stallCount
  );
`else
  modport master (
    input  imemData, stall, redirect, redirectPC,
    output imemRd, imemAddr, instValid, instr, opCode, funct, pc, pcPlus4
  );
  modport slave (
    output imemData, stall, redirect, redirectPC,
    input  imemRd, imemAddr, instValid, instr, opCode, funct, pc, pcPlus4
  );
`endif
endinterface
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Sequential instruction fetch front end. Issues word reads to
//               a synchronous (1-cycle) instruction memory, buffers returned
//               words in a 2-entry FIFO and presents the head instruction.
//               Redirects flush the FIFO, drop the in-flight word and refetch
//               in the same cycle. Define FETCH_PERF_EN to add the
//               fetchCount / stallCount performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic     clk,
  input  wire logic     reset,
  instr_fetch_if.master bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_stateNext;
  logic [31:0] r_fpc;
  logic        r_inflight;
  logic [31:0] r_inflightAddr;
  logic [31:0] r_qData [2];
  logic [31:0] r_qAddr [2];
  logic        r_rdPtr;
  logic        r_wrPtr;
  logic [1:0]  r_count;

  logic        w_pop;
  logic        w_push;
  logic        w_squash;
  logic        w_issue;
  logic [31:0] w_issueAddr;
  logic [31:0] w_redirAddr;
  logic [2:0]  w_occupancy;
  logic        w_valid;

  assign w_redirAddr = bus.redirectPC & 32'hFFFF_FFFC;
  assign w_valid     = (r_count != 2'd0);
  assign w_pop       = w_valid & ~bus.stall;
  // A redirect in RUN flushes the FIFO and drops the word arriving this cycle.
  assign w_squash    = bus.redirect & (r_state == S_RUN);
  assign w_push      = r_inflight & ~w_squash;
  // Slots committed after this cycle's pop; issuing keeps this at most 2.
  assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_stateNext;
  end

  // Next state and fetch-issue decision.
  always_comb begin
    w_stateNext = r_state;
    w_issue     = 1'b0;
    w_issueAddr = r_fpc;
    case (r_state)
      S_IDLE: w_stateNext = S_RUN;
      S_RUN: begin
        if (bus.redirect) begin
          w_issue     = 1'b1;
          w_issueAddr = w_redirAddr;
        end else if (w_occupancy < 3'd2) begin
          w_issue = 1'b1;
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  // Fetch PC and in-flight read tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fpc          <= RESET_PC;
      r_inflight     <= 1'b0;
      r_inflightAddr <= 32'h0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflightAddr <= w_issueAddr;
        r_fpc          <= w_issueAddr + 32'd4;
      end
    end
  end

  // Two-entry FIFO of fetched words tagged with their addresses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= 2'd0;
      r_rdPtr <= 1'b0;
      r_wrPtr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_qData[i] <= 32'h0;
        r_qAddr[i] <= 32'h0;
      end
    end else if (w_squash) begin
      r_count <= 2'd0;
      r_rdPtr <= 1'b0;
      r_wrPtr <= 1'b0;
    end else begin
      if (w_push) begin
        r_qData[r_wrPtr] <= bus.imemData;
        r_qAddr[r_wrPtr] <= r_inflightAddr;
        r_wrPtr          <= ~r_wrPtr;
      end
      if (w_pop) r_rdPtr <= ~r_rdPtr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign bus.imemRd    = w_issue;
  assign bus.imemAddr  = w_issueAddr;
  assign bus.instValid = w_valid;
  assign bus.instr     = w_valid ? r_qData[r_rdPtr] : 32'h0;
  assign bus.pc        = w_valid ? r_qAddr[r_rdPtr] : 32'h0;
  assign bus.pcPlus4   = bus.pc + 32'd4;
  assign bus.opCode    = bus.instr[31:26];
  assign bus.funct     = bus.instr[5:0];

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetchCount;
  logic [31:0] r_stallCount;

  // Free-running event counters; only reset clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetchCount <= 32'h0;
      r_stallCount <= 32'h0;
    end else begin
      if (w_issue)             r_fetchCount <= r_fetchCount + 32'd1;
      if (w_valid & bus.stall) r_stallCount <= r_stallCount + 32'd1;
    end
  end

  assign bus.fetchCount = r_fetchCount;
  assign bus.stallCount = r_stallCount;
`endif

`ifndef SYNTHESIS
  a_noOverflow : assert property (@(posedge clk) disable iff (reset)
    !(w_push && !w_pop && (r_count == 2'd2)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Scoreboard bench for instr_fetch. Stimulus pushes the pc
//               sequence the consumer should see; a negedge monitor pops and
//               compares each consumed instruction. Memory returns a pattern
//               derived from the address one cycle after each read.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   nChecks = 0;
  int   nFails  = 0;
  int   cyc     = 0;
  logic [31:0] expQ [$];
  logic [31:0] monExp;
  logic [31:0] monWord;

  instr_fetch_if bus ();

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[7:2] ^ 6'h2A, a[27:2]};
  endfunction

  // Synchronous instruction memory model.
  always @(posedge clk) begin
    if (bus.imemRd) bus.imemData <= memWord(bus.imemAddr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every consumed head instruction is compared with the scoreboard.
  always @(negedge clk) begin
    if (!reset && bus.instValid && !bus.stall) begin
      if (expQ.size() == 0) begin
        nChecks++;
        nFails++;
        $display("FAIL unexpected_instr (cycle %0d): got pc %h, expected no instruction", cyc, bus.pc);
      end else begin
        monExp  = expQ.pop_front();
        monWord = memWord(monExp);
        check("pc", bus.pc, monExp);
        check("instr", bus.instr, monWord);
        check("opCode", {26'h0, bus.opCode}, {26'h0, monWord[31:26]});
        check("funct", {26'h0, bus.funct}, {26'h0, monWord[5:0]});
        check("pcPlus4", bus.pcPlus4, monExp + 32'd4);
      end
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic runTo(input int n);
    while (cyc < n) nextCycle();
  endtask

  task automatic pushSeq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) expQ.push_back(start + 32'(4 * i));
  endtask

  task automatic drain();
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(expQ.size()), 32'd0);
  endtask

  task automatic releaseReset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
    #1;
    check("idle_no_rd", {31'h0, bus.imemRd}, 32'd0);
  endtask

  task automatic doReset();
    reset          = 1'b1;
    bus.stall      = 1'b0;
    bus.redirect   = 1'b0;
    bus.redirectPC = 32'h0;
    #1;
    check("rst_imemRd", {31'h0, bus.imemRd}, 32'd0);
    check("rst_imemAddr", bus.imemAddr, 32'h0);
    check("rst_instValid", {31'h0, bus.instValid}, 32'd0);
    check("rst_instr", bus.instr, 32'h0);
    check("rst_pc", bus.pc, 32'h0);
    check("rst_pcPlus4", bus.pcPlus4, 32'd4);
    releaseReset();
  endtask

  // First-fetch timing after reset release: rd in 1, valid in 3.
  task automatic firstFetch();
    nextCycle();
    check("c1_imemRd", {31'h0, bus.imemRd}, 32'd1);
    check("c1_imemAddr", bus.imemAddr, 32'h0);
    nextCycle();
    check("c2_instValid", {31'h0, bus.instValid}, 32'd0);
    check("c2_imemAddr", bus.imemAddr, 32'h4);
    nextCycle();
    check("c3_instValid", {31'h0, bus.instValid}, 32'd1);
    check("c3_pc", bus.pc, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    // Scenario 1: free-running stream.
    pushSeq(32'h0, 12);
    doReset();
    firstFetch();
    runTo(14);
`ifdef FETCH_PERF_EN
    check("perf_fetchCount", bus.fetchCount, 32'd13);
`endif
    drain();

    // Scenario 2: stall for cycles 6..10.
    pushSeq(32'h0, 9);
    doReset();
    runTo(5);
    for (int i = 6; i <= 10; i++) begin
      nextCycle();
      bus.stall = 1'b1;
      #1;
      check("stall_pc_hold", bus.pc, 32'd12);
      check("stall_valid", {31'h0, bus.instValid}, 32'd1);
      check("stall_no_rd", {31'h0, bus.imemRd}, 32'd0);
    end
    nextCycle();
    bus.stall = 1'b0;
    #1;
    check("resume_imemRd", {31'h0, bus.imemRd}, 32'd1);
    check("resume_imemAddr", bus.imemAddr, 32'd20);
`ifdef FETCH_PERF_EN
    check("perf_stallCount", bus.stallCount, 32'd5);
`endif
    runTo(16);
    drain();

    // Scenario 3: redirect in cycle 8 with a read in flight.
    pushSeq(32'h0, 6);
    pushSeq(32'h100, 4);
    doReset();
    runTo(7);
    nextCycle();
    bus.redirect   = 1'b1;
    bus.redirectPC = 32'h0000_0103;
    #1;
    check("redir_imemRd", {31'h0, bus.imemRd}, 32'd1);
    check("redir_imemAddr", bus.imemAddr, 32'h100);
    nextCycle();
    bus.redirect = 1'b0;
    #1;
    check("redir_bubble", {31'h0, bus.instValid}, 32'd0);
    nextCycle();
    check("redir_valid", {31'h0, bus.instValid}, 32'd1);
    check("redir_pc", bus.pc, 32'h100);
    runTo(13);
    drain();

    // Scenario 4: redirect together with stall and a full FIFO.
    pushSeq(32'h0, 3);
    pushSeq(32'h200, 3);
    doReset();
    runTo(5);
    for (int i = 6; i <= 8; i++) begin
      nextCycle();
      bus.stall = 1'b1;
    end
    #1;
    check("full_no_rd", {31'h0, bus.imemRd}, 32'd0);
    nextCycle();
    bus.redirect   = 1'b1;
    bus.redirectPC = 32'h200;
    #1;
    check("full_redir_rd", {31'h0, bus.imemRd}, 32'd1);
    check("full_redir_addr", bus.imemAddr, 32'h200);
    nextCycle();
    bus.stall    = 1'b0;
    bus.redirect = 1'b0;
    #1;
    check("full_redir_flushed", {31'h0, bus.instValid}, 32'd0);
    nextCycle();
    check("full_redir_pc", bus.pc, 32'h200);
    runTo(13);
    drain();

    // Scenario 5: address wrap-around.
    expQ.push_back(32'h0);
    expQ.push_back(32'h4);
    expQ.push_back(32'hFFFF_FFFC);
    expQ.push_back(32'h0);
    expQ.push_back(32'h4);
    doReset();
    runTo(3);
    nextCycle();
    bus.redirect   = 1'b1;
    bus.redirectPC = 32'hFFFF_FFFE;
    #1;
    check("wrap_imemAddr", bus.imemAddr, 32'hFFFF_FFFC);
    nextCycle();
    bus.redirect = 1'b0;
    #1;
    check("wrap_next_addr", bus.imemAddr, 32'h0);
    nextCycle();
    check("wrap_pc", bus.pc, 32'hFFFF_FFFC);
    check("wrap_pcPlus4", bus.pcPlus4, 32'h0);
    runTo(8);
    drain();

    // Scenario 6: asynchronous reset mid-stream, then restart.
    pushSeq(32'h0, 5);
    doReset();
    runTo(7);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_instValid", {31'h0, bus.instValid}, 32'd0);
    check("async_imemRd", {31'h0, bus.imemRd}, 32'd0);
    check("async_instr", bus.instr, 32'h0);
`ifdef FETCH_PERF_EN
    check("async_fetchCount", bus.fetchCount, 32'd0);
    check("async_stallCount", bus.stallCount, 32'd0);
`endif
    check("async_drained", 32'(expQ.size()), 32'd0);
    pushSeq(32'h0, 4);
    releaseReset();
    firstFetch();
    runTo(6);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
`default_nettype wire
